// File: rtl/sw_rx_engine.sv
// rtl/sw_rx_engine.sv - SRIO SWRITE target receiver: header check, byte swap, AXI4 burst or c2h forward
// Optional build macro: SW_RX_DESTID_CHECK_EN (drop headers whose destination ID is not C_SRIO_DEV_ID)
module sw_rx_engine #(
  parameter logic [15:0] C_SRIO_DEV_ID = 16'h7801,
  parameter int          C_MAX_BEATS   = 32
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        sw_mode,
  output logic        sw_rx_done,
  output logic        sw_rx_err,
  output logic [31:0] sw_rx_addr,
  input  logic        s_axis_treq_tvalid,
  output logic        s_axis_treq_tready,
  input  logic        s_axis_treq_tlast,
  input  logic [63:0] s_axis_treq_tdata,
  input  logic [31:0] s_axis_treq_tuser,
  output logic [31:0] m_axi_awaddr,
  output logic [7:0]  m_axi_awlen,
  output logic [2:0]  m_axi_awsize,
  output logic [1:0]  m_axi_awburst,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [63:0] m_axi_wdata,
  output logic [7:0]  m_axi_wstrb,
  output logic        m_axi_wlast,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic        m_axis_c2h_tvalid,
  input  logic        m_axis_c2h_tready,
  output logic        m_axis_c2h_tlast,
  output logic [63:0] m_axis_c2h_tdata,
  output logic [7:0]  m_axis_c2h_tkeep
);

  localparam int AW = (C_MAX_BEATS > 1) ? $clog2(C_MAX_BEATS) : 1;
  localparam int CW = $clog2(C_MAX_BEATS + 1);

  typedef enum logic [2:0] {S_IDLE, S_BUF, S_AW, S_W, S_B, S_PASS, S_DROP} state_t;
  state_t state, state_d;

  logic          run;
  logic [31:0]   addr_q;
  logic [CW-1:0] cnt;
  logic          ovf;
  logic [7:0]    awlen_q;
  logic [AW-1:0] rd_ptr;
  logic          done_d, err_d, done_q, err_q;
  logic          hdr_ok, treq_hs, buf_full;
  logic [63:0]   treq_swap;
  logic [63:0]   buf_mem [C_MAX_BEATS];

  function automatic logic [63:0] bswap(input logic [63:0] d);
    for (int i = 0; i < 8; i++) bswap[8*i +: 8] = d[56-8*i +: 8];
  endfunction

`ifdef SW_RX_DESTID_CHECK_EN
  assign hdr_ok = (s_axis_treq_tdata[55:48] == 8'h60) && (s_axis_treq_tuser[15:0] == C_SRIO_DEV_ID);
  logic unused_tuser;
  assign unused_tuser = &{1'b0, s_axis_treq_tuser[31:16]};
`else
  assign hdr_ok = (s_axis_treq_tdata[55:48] == 8'h60);
  logic unused_tuser;
  assign unused_tuser = &{1'b0, s_axis_treq_tuser, C_SRIO_DEV_ID};
`endif

  assign treq_swap = bswap(s_axis_treq_tdata);
  assign treq_hs   = s_axis_treq_tvalid && s_axis_treq_tready;
  assign buf_full  = (cnt == CW'(C_MAX_BEATS));

  assign sw_rx_done    = done_q;
  assign sw_rx_err     = err_q;
  assign sw_rx_addr    = addr_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awsize  = 3'b011;
  assign m_axi_awburst = 2'b01;
  assign m_axi_wdata   = buf_mem[rd_ptr];
  assign m_axi_wstrb   = 8'hFF;
  assign m_axi_wlast   = (rd_ptr == awlen_q[AW-1:0]);
  assign m_axis_c2h_tdata = treq_swap;
  assign m_axis_c2h_tkeep = 8'hFF;
  assign m_axis_c2h_tlast = (state == S_PASS) && s_axis_treq_tlast;

  always_comb begin
    state_d            = state;
    done_d             = 1'b0;
    err_d              = 1'b0;
    s_axis_treq_tready = 1'b0;
    m_axi_awvalid      = 1'b0;
    m_axi_wvalid       = 1'b0;
    m_axi_bready       = 1'b0;
    m_axis_c2h_tvalid  = 1'b0;
    case (state)
      S_IDLE: begin
        // run holds tready low for the first cycle out of reset
        s_axis_treq_tready = run;
        if (s_axis_treq_tvalid && run) begin
          if (s_axis_treq_tlast) err_d   = 1'b1;
          else if (!hdr_ok)      state_d = S_DROP;
          else if (sw_mode)      state_d = S_BUF;
          else                   state_d = S_PASS;
        end
      end
      S_BUF: begin
        s_axis_treq_tready = 1'b1;
        if (s_axis_treq_tvalid && s_axis_treq_tlast) begin
          if (ovf || buf_full) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_AW;
          end
        end
      end
      S_AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_d = S_W;
      end
      S_W: begin
        m_axi_wvalid = 1'b1;
        if (m_axi_wready && m_axi_wlast) state_d = S_B;
      end
      S_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00) err_d = 1'b1;
          else                      done_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_PASS: begin
        s_axis_treq_tready = m_axis_c2h_tready;
        m_axis_c2h_tvalid  = s_axis_treq_tvalid;
        if (s_axis_treq_tvalid && m_axis_c2h_tready && s_axis_treq_tlast) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DROP: begin
        s_axis_treq_tready = 1'b1;
        if (s_axis_treq_tvalid && s_axis_treq_tlast) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= S_IDLE;
      run     <= 1'b0;
      addr_q  <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      awlen_q <= '0;
      rd_ptr  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state  <= state_d;
      run    <= 1'b1;
      done_q <= done_d;
      err_q  <= err_d;
      if (state == S_IDLE && treq_hs) begin
        addr_q <= s_axis_treq_tdata[31:0];
        cnt    <= '0;
        ovf    <= 1'b0;
      end
      // cnt before increment on the tlast beat equals final count minus one
      if (state == S_BUF && treq_hs) begin
        if (buf_full) ovf <= 1'b1;
        else          cnt <= cnt + 1'b1;
        if (s_axis_treq_tlast) awlen_q <= 8'(cnt);
      end
      if (state == S_AW) rd_ptr <= '0;
      if (m_axi_wvalid && m_axi_wready) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (state == S_BUF && treq_hs && !buf_full) buf_mem[cnt[AW-1:0]] <= treq_swap;
  end

endmodule

// File: tb/tb_sw_rx_engine.sv
// tb/tb_sw_rx_engine.sv - self-checking bench for sw_rx_engine against a packet-level reference model
module tb_sw_rx_engine;

  logic        aclk, aresetn, sw_mode;
  logic        sw_rx_done, sw_rx_err;
  logic [31:0] sw_rx_addr;
  logic        s_axis_treq_tvalid, s_axis_treq_tready, s_axis_treq_tlast;
  logic [63:0] s_axis_treq_tdata;
  logic [31:0] s_axis_treq_tuser;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awvalid, m_axi_awready;
  logic [63:0] m_axi_wdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid, m_axi_bready;
  logic        m_axis_c2h_tvalid, m_axis_c2h_tready, m_axis_c2h_tlast;
  logic [63:0] m_axis_c2h_tdata;
  logic [7:0]  m_axis_c2h_tkeep;

  sw_rx_engine dut (
    .aclk(aclk), .aresetn(aresetn), .sw_mode(sw_mode),
    .sw_rx_done(sw_rx_done), .sw_rx_err(sw_rx_err), .sw_rx_addr(sw_rx_addr),
    .s_axis_treq_tvalid(s_axis_treq_tvalid), .s_axis_treq_tready(s_axis_treq_tready),
    .s_axis_treq_tlast(s_axis_treq_tlast), .s_axis_treq_tdata(s_axis_treq_tdata),
    .s_axis_treq_tuser(s_axis_treq_tuser),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axis_c2h_tvalid(m_axis_c2h_tvalid), .m_axis_c2h_tready(m_axis_c2h_tready),
    .m_axis_c2h_tlast(m_axis_c2h_tlast), .m_axis_c2h_tdata(m_axis_c2h_tdata),
    .m_axis_c2h_tkeep(m_axis_c2h_tkeep)
  );

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int done_cnt = 0, err_cnt = 0, wlast_cnt = 0, bhs_cnt = 0, b_issued = 0;
  bit w_hold = 0, c2h_toggle = 0;
  logic [1:0] bresp_cfg = 2'b00;
  logic [44:0] aw_q[$];
  logic [72:0] w_q[$];
  logic [72:0] c2h_q[$];

  initial begin
    aclk = 0;
    forever #5 aclk = ~aclk;
  end

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_swap(input logic [63:0] x);
    logic [63:0] r;
    r = {<<8{x}};
    return r;
  endfunction

  // Monitor: samples mid-cycle, each handshake seen here completes on the next rising edge
  initial begin
    forever begin
      @(negedge aclk);
      if (m_axi_awvalid && m_axi_awready)
        aw_q.push_back({m_axi_awburst, m_axi_awsize, m_axi_awlen, m_axi_awaddr});
      if (m_axi_wvalid && m_axi_wready) begin
        w_q.push_back({m_axi_wstrb, m_axi_wlast, m_axi_wdata});
        if (m_axi_wlast) wlast_cnt++;
      end
      if (m_axi_bvalid && m_axi_bready) bhs_cnt++;
      if (m_axis_c2h_tvalid && m_axis_c2h_tready)
        c2h_q.push_back({m_axis_c2h_tkeep, m_axis_c2h_tlast, m_axis_c2h_tdata});
      if (sw_rx_done) done_cnt++;
      if (sw_rx_err) err_cnt++;
    end
  end

  // AXI slave and c2h sink with random back-pressure
  initial begin
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0; m_axis_c2h_tready = 0;
    forever begin
      @(posedge aclk); #1;
      m_axi_awready     = 1'($urandom_range(0, 1));
      m_axi_wready      = w_hold ? 1'b0 : 1'($urandom_range(0, 1));
      m_axis_c2h_tready = c2h_toggle ? ~m_axis_c2h_tready : 1'($urandom_range(0, 1));
      if (m_axi_bvalid && bhs_cnt == b_issued) m_axi_bvalid = 0;
      else if (!m_axi_bvalid && wlast_cnt > b_issued && $urandom_range(0, 1) == 1) begin
        m_axi_bvalid = 1;
        m_axi_bresp  = bresp_cfg;
        b_issued++;
      end
    end
  end

  task automatic send_beat(input logic [63:0] d, input logic l);
    int t;
    bit ok;
    repeat ($urandom_range(0, 2)) begin
      s_axis_treq_tvalid = 0;
      @(posedge aclk); #1;
    end
    s_axis_treq_tvalid = 1; s_axis_treq_tdata = d; s_axis_treq_tlast = l;
    ok = 0; t = 0;
    while (!ok && t < 400) begin
      @(negedge aclk);
      if (s_axis_treq_tready) ok = 1;
      t++;
    end
    @(posedge aclk); #1;
    s_axis_treq_tvalid = 0; s_axis_treq_tlast = 0;
    if (!ok) chk("treq_accept_timeout", 0, 1);
  endtask

  task automatic run_pkt(input bit mode, input logic [7:0] ftype, input int len, input logic [1:0] br,
                         input logic [15:0] dest, input logic [31:0] addr, input bit fixed);
    logic [63:0] pay[$];
    bit hok, exp_buf, exp_pass, exp_done;
    int d0, e0, t;
    for (int i = 0; i < len; i++) pay.push_back(fixed ? 64'h0102030405060708 + 64'(i) : {$urandom, $urandom});
    aw_q.delete(); w_q.delete(); c2h_q.delete();
    bresp_cfg = br; sw_mode = mode;
    d0 = done_cnt; e0 = err_cnt;
    s_axis_treq_tuser = {16'($urandom), dest};
    send_beat({8'h00, ftype, 16'h0000, addr}, len == 0);
    sw_mode = 1'($urandom_range(0, 1));
    for (int i = 0; i < len; i++) send_beat(pay[i], i == len - 1);
    t = 0;
    while (done_cnt + err_cnt == d0 + e0 && t < 3000) begin
      @(posedge aclk);
      t++;
    end
    repeat (4) @(posedge aclk);
    #1;
    hok = (ftype == 8'h60);
`ifdef SW_RX_DESTID_CHECK_EN
    hok = hok && (dest == 16'h7801);
`endif
    exp_buf  = (len > 0) && hok && mode && (len <= 32);
    exp_pass = (len > 0) && hok && !mode;
    exp_done = exp_pass || (exp_buf && br == 2'b00);
    chk("done_pulses", 80'(done_cnt - d0), 80'(exp_done));
    chk("err_pulses", 80'(err_cnt - e0), 80'(!exp_done));
    chk("rx_addr", 80'(sw_rx_addr), 80'(addr));
    chk("aw_count", 80'(aw_q.size()), 80'(exp_buf));
    if (exp_buf && aw_q.size() > 0)
      chk("aw_fields", 80'(aw_q[0]), 80'({2'b01, 3'b011, 8'(len - 1), addr}));
    chk("w_count", 80'(w_q.size()), 80'(exp_buf ? len : 0));
    for (int i = 0; exp_buf && i < w_q.size() && i < len; i++)
      chk("w_beat", 80'(w_q[i]), 80'({8'hFF, i == len - 1, ref_swap(pay[i])}));
    chk("c2h_count", 80'(c2h_q.size()), 80'(exp_pass ? len : 0));
    for (int i = 0; exp_pass && i < c2h_q.size() && i < len; i++)
      chk("c2h_beat", 80'(c2h_q[i]), 80'({8'hFF, i == len - 1, ref_swap(pay[i])}));
  endtask

  initial begin
    int t;
    logic [7:0] ft;
    aresetn = 0; sw_mode = 0;
    s_axis_treq_tvalid = 0; s_axis_treq_tlast = 0; s_axis_treq_tdata = 0; s_axis_treq_tuser = 0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_tready", 80'(s_axis_treq_tready), 0);
    chk("rst_awvalid", 80'(m_axi_awvalid), 0);
    chk("rst_wvalid", 80'(m_axi_wvalid), 0);
    chk("rst_bready", 80'(m_axi_bready), 0);
    chk("rst_c2h_tvalid", 80'(m_axis_c2h_tvalid), 0);
    chk("rst_done_err", 80'({sw_rx_done, sw_rx_err}), 0);
    chk("rst_addr", 80'(sw_rx_addr), 0);
    @(posedge aclk); #1;
    aresetn = 1;

    run_pkt(1, 8'h60, 4, 2'b00, 16'h7801, 32'h8000_1000, 1);
    c2h_toggle = 1;
    run_pkt(0, 8'h60, 3, 2'b00, 16'h7801, 32'h0000_2000, 0);
    c2h_toggle = 0;
    run_pkt(1, 8'h50, 2, 2'b00, 16'h7801, 32'h0000_3000, 0);
    run_pkt(1, 8'h60, 5, 2'b00, 16'h7801, 32'h0000_4000, 0);
    run_pkt(1, 8'h60, 33, 2'b00, 16'h7801, 32'h0000_5000, 0);
    run_pkt(1, 8'h60, 32, 2'b00, 16'h7801, 32'h0000_6000, 0);
    run_pkt(0, 8'h60, 40, 2'b00, 16'h7801, 32'h0000_6800, 0);
    run_pkt(1, 8'h60, 3, 2'b10, 16'h7801, 32'h0000_7000, 0);
    run_pkt(1, 8'h60, 0, 2'b00, 16'h7801, 32'h0000_7800, 0);
    run_pkt(1, 8'h60, 3, 2'b00, 16'h1234, 32'h0000_8000, 0);
    run_pkt(1, 8'h60, 3, 2'b00, 16'h7801, 32'h0000_9000, 0);

    // Reset while the engine is stalled in the W phase
    aw_q.delete(); w_q.delete();
    w_hold = 1; sw_mode = 1; s_axis_treq_tuser = 32'h0000_7801;
    send_beat(64'h0060_0000_A000_0040, 0);
    send_beat(64'h1111_2222_3333_4444, 0);
    send_beat(64'h5555_6666_7777_8888, 1);
    t = 0;
    while (aw_q.size() == 0 && t < 200) begin
      @(posedge aclk);
      t++;
    end
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("stall_aw_seen", 80'(aw_q.size()), 1);
    chk("stall_wvalid", 80'(m_axi_wvalid), 1);
    chk("stall_backpressure", 80'(s_axis_treq_tready), 0);
    @(posedge aclk); #1;
    aresetn = 0;
    @(negedge aclk);
    chk("midrst_wvalid", 80'(m_axi_wvalid), 0);
    chk("midrst_awvalid", 80'(m_axi_awvalid), 0);
    chk("midrst_tready", 80'(s_axis_treq_tready), 0);
    chk("midrst_addr", 80'(sw_rx_addr), 0);
    @(posedge aclk); #1;
    aresetn = 1; w_hold = 0;
    run_pkt(1, 8'h60, 4, 2'b00, 16'h7801, 32'h0000_B000, 0);

    for (int k = 0; k < 30; k++) begin
      ft = ($urandom_range(0, 99) < 80) ? 8'h60 : (($urandom_range(0, 1) == 1) ? 8'h50 : 8'($urandom));
      run_pkt(1'($urandom_range(0, 1)), ft, $urandom_range(0, 34),
              ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00,
              ($urandom_range(0, 3) == 0) ? 16'h1234 : 16'h7801, $urandom, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
